// File: rtl/rv_scoreboard.sv
// RAW/WAW scoreboard: per-register pending-write counters for the int and FP register files.
// Optional sticky underflow error is enabled by defining SCOREBOARD_UNDERFLOW_CHECK_EN.
module rv_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_WB   = 2,
    parameter int unsigned CNT_W    = 2,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic                 issue_wr,
    input  logic                 issue_rd_fp,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    input  logic [AW-1:0]        rs3,
    input  logic                 rs1_fp,
    input  logic                 rs2_fp,
    input  logic                 rs3_fp,
    input  logic [2:0]           rs_used,
    input  logic [2:0]           fwd_hit,
    input  logic [NUM_WB-1:0]    wb_valid,
    input  logic [NUM_WB-1:0]    wb_fp,
    input  logic [NUM_WB*AW-1:0] wb_rd,
    input  logic [AW-1:0]        lu_rd,
    input  logic                 lu_fp,
    output logic                 issue_fire,
    output logic                 raw_stall,
    output logic                 waw_stall,
    output logic                 lu_busy,
    output logic                 sb_err
);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CntMax = {CNT_W{1'b1}};

    cnt_t          cnt_int_q [NUM_REGS];
    cnt_t          cnt_int_d [NUM_REGS];
    cnt_t          cnt_fp_q  [NUM_REGS];
    cnt_t          cnt_fp_d  [NUM_REGS];

    logic [AW-1:0] rs_addr [3];
    logic [2:0]    rs_fp;
    cnt_t          rs_cnt [3];
    logic [2:0]    src_busy;
    cnt_t          rd_cnt;
    cnt_t          lu_cnt;

    logic          inc_en;
    int unsigned   dec_int [NUM_REGS];
    int unsigned   dec_fp  [NUM_REGS];
    int unsigned   tot_int;
    int unsigned   tot_fp;
`ifdef SCOREBOARD_UNDERFLOW_CHECK_EN
    logic          underflow;
`endif

    always_comb begin
        rs_addr[0] = rs1;
        rs_addr[1] = rs2;
        rs_addr[2] = rs3;
        rs_fp      = {rs3_fp, rs2_fp, rs1_fp};
        src_busy   = '0;
        for (int k = 0; k < 3; k++) begin
            rs_cnt[k]   = rs_fp[k] ? cnt_fp_q[rs_addr[k]] : cnt_int_q[rs_addr[k]];
            // Bypass only covers the youngest producer, so only a count of 1 can be forwarded.
            src_busy[k] = rs_used[k] && (rs_cnt[k] != '0)
                          && !((rs_cnt[k] == cnt_t'(1)) && fwd_hit[k]);
        end
        rd_cnt     = issue_rd_fp ? cnt_fp_q[issue_rd] : cnt_int_q[issue_rd];
        lu_cnt     = lu_fp ? cnt_fp_q[lu_rd] : cnt_int_q[lu_rd];
        raw_stall  = issue_valid && (|src_busy);
        waw_stall  = issue_valid && issue_wr && (rd_cnt == CntMax)
                     && (issue_rd_fp || (issue_rd != '0));
        issue_fire = issue_valid && !raw_stall && !waw_stall;
        lu_busy    = (lu_cnt != '0);
    end

    always_comb begin
        inc_en  = issue_fire && issue_wr;
        tot_int = 0;
        tot_fp  = 0;
`ifdef SCOREBOARD_UNDERFLOW_CHECK_EN
        underflow = 1'b0;
`endif
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_int[r] = 0;
            dec_fp[r]  = 0;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                if (wb_fp[p]) dec_fp[wb_rd[p*AW +: AW]] += 1;
                else          dec_int[wb_rd[p*AW +: AW]] += 1;
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            tot_int = 32'(cnt_int_q[r]) + 32'(inc_en && !issue_rd_fp && (issue_rd == AW'(r)));
            tot_fp  = 32'(cnt_fp_q[r]) + 32'(inc_en && issue_rd_fp && (issue_rd == AW'(r)));
            // Net delta per register; decrements past zero saturate.
            cnt_int_d[r] = (tot_int >= dec_int[r]) ? cnt_t'(tot_int - dec_int[r]) : '0;
            cnt_fp_d[r]  = (tot_fp >= dec_fp[r]) ? cnt_t'(tot_fp - dec_fp[r]) : '0;
`ifdef SCOREBOARD_UNDERFLOW_CHECK_EN
            if (tot_fp < dec_fp[r]) underflow = 1'b1;
            if ((r != 0) && (tot_int < dec_int[r])) underflow = 1'b1;
`endif
            if (r == 0) cnt_int_d[r] = '0;
            if (flush) begin
                cnt_int_d[r] = '0;
                cnt_fp_d[r]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_int_q[r] <= '0;
                cnt_fp_q[r]  <= '0;
            end
        end else begin
            cnt_int_q <= cnt_int_d;
            cnt_fp_q  <= cnt_fp_d;
        end
    end

`ifdef SCOREBOARD_UNDERFLOW_CHECK_EN
    logic sb_err_q;
    logic sb_err_d;

    assign sb_err_d = sb_err_q | underflow;
    assign sb_err   = sb_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sb_err_q <= 1'b0;
        else          sb_err_q <= sb_err_d;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!underflow) else $error("rv_scoreboard: pending counter underflow");
        end
    end
`else
    assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_scoreboard.sv
// Directed bench for rv_scoreboard; counts are read back indirectly through
// lu_busy / bypass / waw_stall probes and compared with hand-computed values.
module tb_rv_scoreboard;
    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       issue_valid;
    logic       issue_wr;
    logic       issue_rd_fp;
    logic [4:0] issue_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic       rs1_fp;
    logic       rs2_fp;
    logic       rs3_fp;
    logic [2:0] rs_used;
    logic [2:0] fwd_hit;
    logic [1:0] wb_valid;
    logic [1:0] wb_fp;
    logic [9:0] wb_rd;
    logic [4:0] lu_rd;
    logic       lu_fp;
    logic       issue_fire;
    logic       raw_stall;
    logic       waw_stall;
    logic       lu_busy;
    logic       sb_err;

    int n_vec  = 0;
    int n_miss = 0;
    int c;

    rv_scoreboard dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd_fp (issue_rd_fp),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs3         (rs3),
        .rs1_fp      (rs1_fp),
        .rs2_fp      (rs2_fp),
        .rs3_fp      (rs3_fp),
        .rs_used     (rs_used),
        .fwd_hit     (fwd_hit),
        .wb_valid    (wb_valid),
        .wb_fp       (wb_fp),
        .wb_rd       (wb_rd),
        .lu_rd       (lu_rd),
        .lu_fp       (lu_fp),
        .issue_fire  (issue_fire),
        .raw_stall   (raw_stall),
        .waw_stall   (waw_stall),
        .lu_busy     (lu_busy),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_wr = 0; issue_rd_fp = 0; issue_rd = 0;
        rs1 = 0; rs2 = 0; rs3 = 0; rs1_fp = 0; rs2_fp = 0; rs3_fp = 0;
        rs_used = 0; fwd_hit = 0; wb_valid = 0; wb_fp = 0; wb_rd = 0; lu_rd = 0; lu_fp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic fp, input logic [4:0] rd);
        issue_valid = 1; issue_wr = 1; issue_rd_fp = fp; issue_rd = rd;
    endtask

    task automatic wb(input int p, input logic fp, input logic [4:0] rd);
        wb_valid[p] = 1'b1; wb_fp[p] = fp; wb_rd[p*5 +: 5] = rd;
    endtask

    // Infers the pending count of one register purely combinationally, then restores idle.
    task automatic probe(input logic fp, input logic [4:0] r, output int cnt);
        issue_valid = 1; issue_wr = 1; issue_rd_fp = fp; issue_rd = r;
        rs1 = r; rs1_fp = fp; rs_used = 3'b001; fwd_hit = 3'b001; lu_rd = r; lu_fp = fp;
        #1;
        if (!lu_busy)        cnt = 0;
        else if (!raw_stall) cnt = 1;
        else if (!waw_stall) cnt = 2;
        else                 cnt = 3;
        idle();
        #1;
    endtask

    initial begin
        idle();
        reset_n = 0;
        #1;
        check("rst raw_stall", raw_stall, 0);
        check("rst waw_stall", waw_stall, 0);
        check("rst lu_busy", lu_busy, 0);
        check("rst sb_err", sb_err, 0);
        issue_valid = 1;
        #1;
        check("rst issue_fire", issue_fire, 1);
        idle();
        #10;
        reset_n = 1;
        step();

        // RAW on x5, write-back in N does not clear stall in N
        issue(0, 5);
        #1 check("x5 issue fire", issue_fire, 1);
        step(); idle();
        issue_valid = 1; rs1 = 5; rs_used = 3'b001;
        wb(0, 0, 5);
        #1;
        check("x5 raw", raw_stall, 1);
        check("x5 raw fire", issue_fire, 0);
        step();
        wb_valid = 0;
        #1;
        check("x5 raw after wb", raw_stall, 0);
        check("x5 fire after wb", issue_fire, 1);
        step(); idle();

        // Two producers: bypass cannot cover count 2
        issue(0, 5); step();
        issue(0, 5); step(); idle();
        probe(0, 5, c); check("x5 cnt2", c, 2);
        issue_valid = 1; rs2 = 5; rs_used = 3'b010; fwd_hit = 3'b010;
        #1 check("x5 cnt2 fwd raw", raw_stall, 1);
        idle(); wb(1, 0, 5); step(); idle();
        issue_valid = 1; rs2 = 5; rs_used = 3'b010; fwd_hit = 3'b010;
        #1 check("x5 cnt1 fwd raw", raw_stall, 0);
        idle(); wb(0, 0, 5); step(); idle();
        probe(0, 5, c); check("x5 drained", c, 0);

        // WAW saturation on f3
        for (int i = 0; i < 3; i++) begin
            issue(1, 3); step();
        end
        idle();
        issue(1, 3);
        #1;
        check("f3 waw", waw_stall, 1);
        check("f3 waw fire", issue_fire, 0);
        step(); idle();
        probe(1, 3, c); check("f3 cnt3 held", c, 3);
        probe(0, 3, c); check("x3 untouched", c, 0);
        wb(0, 1, 3); wb(1, 1, 3); step(); idle();
        probe(1, 3, c); check("f3 double wb", c, 1);
        wb(0, 1, 3); step(); idle();

        // Net delta on x7: 2 + 1 - 2 = 1
        issue(0, 7); step();
        issue(0, 7); step(); idle();
        issue(0, 7); wb(0, 0, 7); wb(1, 0, 7);
        #1 check("x7 net fire", issue_fire, 1);
        step(); idle();
        probe(0, 7, c); check("x7 net cnt", c, 1);
        wb(0, 0, 7); step(); idle();

        // x0 never tracked
        issue(0, 0); wb(1, 0, 0);
        #1;
        check("x0 waw", waw_stall, 0);
        check("x0 fire", issue_fire, 1);
        step(); idle();
        probe(0, 0, c); check("x0 cnt", c, 0);
        issue_valid = 1; rs1 = 0; rs_used = 3'b001;
        #1 check("x0 raw", raw_stall, 0);
        idle();

        // Long-latency busy and flush override
        issue(0, 9); step(); idle();
        lu_rd = 9; lu_fp = 0;
        #1 check("lu x9 busy", lu_busy, 1);
        lu_fp = 1;
        #1 check("lu f9 idle", lu_busy, 0);
        idle();
        issue(1, 9); step(); idle();
        issue(0, 9); flush = 1; step(); idle();
        probe(0, 9, c); check("flush x9", c, 0);
        probe(1, 9, c); check("flush f9", c, 0);

        // Underflow on x4
        wb(0, 0, 4); step(); idle();
        probe(0, 4, c); check("x4 underflow sat", c, 0);
`ifdef SCOREBOARD_UNDERFLOW_CHECK_EN
        check("sb_err set", sb_err, 1);
        flush = 1; step(); idle();
        check("sb_err held flush", sb_err, 1);
        reset_n = 0;
        #1 check("sb_err reset", sb_err, 0);
        reset_n = 1;
`else
        check("sb_err tied", sb_err, 0);
`endif

        // Asynchronous reset mid-operation
        step();
        issue(0, 12); step(); idle();
        probe(0, 12, c); check("x12 pending", c, 1);
        reset_n = 0;
        #1;
        probe(0, 12, c); check("async reset clears", c, 0);
        #3 reset_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rv_scoreboard.md
# rv_scoreboard

Parametrised RAW/WAW scoreboard for the RV32IMF core, sitting beside the ID/EXE boundary and driving the hazard unit. It tracks in-flight writes to the integer and FP register files with a per-register pending counter, so several instructions may target the same rd. It accepts multiple write-back ports per cycle and honours operand bypass. It produces issue stall and long-latency-unit busy indications.

## Interface
- NUM_REGS, 32: registers per file; address width AW = $clog2(NUM_REGS).
- NUM_WB, 2: write-back ports, for example the main pipe and the divide/FPU long-latency unit.
- CNT_W, 2: pending-counter width; maximum in-flight writes per register = 2^CNT_W-1.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all counters (pipeline flush).
- issue_valid  in  1  ID-stage instruction wants to issue.
- issue_wr  in  1  instruction writes a register.
- issue_rd_fp  in  1  rd belongs to the FP file.
- issue_rd  in  AW  destination address.
- rs1, rs2, rs3  in  AW each  source addresses; rs3 is used only for FMA.
- rs1_fp, rs2_fp, rs3_fp  in  1 each  source is an FP register.
- rs_used  in  3  per-source valid, bit0 = rs1.
- fwd_hit  in  3  source satisfied this cycle by EXE/MEM bypass.
- wb_valid  in  NUM_WB  write-back port commits.
- wb_fp  in  NUM_WB  write-back targets the FP file.
- wb_rd  in  NUM_WB*AW  write-back addresses, port p at [p*AW +: AW].
- lu_rd, lu_fp  in  AW, 1  query address for the long-latency unit.
- issue_fire  out  1  issue_valid & ~raw_stall & ~waw_stall.
- raw_stall  out  1  a used source has an unsatisfied pending write.
- waw_stall  out  1  the issue rd counter is saturated.
- lu_busy  out  1  queried register has pending count > 0.
- sb_err  out  1  sticky counter underflow error (see Configuration).

## Operation
- State: cnt_int[NUM_REGS] and cnt_fp[NUM_REGS], each CNT_W bits. The int x0 counter is constant 0 and never increments. FP f0 is tracked normally.
- Source busy rule: source k is busy if rs_used[k] and cnt(rs_k) > 0, except when cnt == 1 and fwd_hit[k].
  - A count of 2 or more always stalls, because bypass only covers the youngest producer.
- raw_stall = issue_valid & OR over busy sources.
- waw_stall = issue_valid & issue_wr & cnt(issue_rd) == max, excluding int x0.
- Increment: on issue_fire & issue_wr, +1 to the selected file[issue_rd].
- Decrement: each wb_valid[p] subtracts 1 from file wb_fp[p] [wb_rd[p]].
  - Several ports hitting the same register subtract the number of hits.
- Same-cycle increment and decrement on one register apply the net delta.
- A decrement below 0 saturates at 0 and sets the underflow condition.
- Write-backs to int x0 are ignored.
- flush forces all counters to 0 next cycle and overrides same-cycle increment/decrement. sb_err is not cleared by flush.
- lu_busy = cnt(lu_fp ? fp : int)[lu_rd] != 0, with lu_rd = 0 and lu_fp = 0 giving 0.

## Timing
- Reset values: all counters 0 and sb_err = 0.
  - After reset, raw_stall = 0, waw_stall = 0, lu_busy = 0, and issue_fire = issue_valid.
- All stall and busy outputs are combinational from the current counters and inputs. There is zero-cycle latency from issue to stall.
- Counter updates are visible one clk after issue_fire or wb_valid.
- A write-back in cycle N does not clear a stall in cycle N. The consumer issues in N+1, unless fwd_hit covers it in N.
- reset_n asserted mid-operation clears state immediately and asynchronously. Release is synchronised externally.

## Configuration
- Macro SCOREBOARD_UNDERFLOW_CHECK_EN.
- Defined: sb_err latches 1 on any underflow, held until reset_n. A simulation assertion also fires on underflow.
- Undefined: sb_err is tied 0, no error logic or assertion is generated, and underflow still saturates at 0.

## Test plan
- Issue wr x5, then next cycle issue rs1=x5 with fwd_hit=0: raw_stall=1. wb x5 on port 0: the following cycle raw_stall=0.
- Issue wr x5 twice (cnt=2), consumer rs2=x5 with fwd_hit[1]=1: raw_stall=1. After one wb (cnt=1) with fwd_hit[1]=1: raw_stall=0.
- CNT_W=2, three issues to f3 (cnt=3), fourth issue to f3: waw_stall=1, issue_fire=0, cnt stays 3.
- Same cycle: issue to x7 plus wb on ports 0 and 1 to x7, from cnt=2: next cnt=1. Int x0 issue and wb: cnt stays 0 and no stalls.
- Pending div to x9 with lu_rd=9, lu_fp=0: lu_busy=1. Assert flush: next cycle all counts 0 and lu_busy=0.
- With SCOREBOARD_UNDERFLOW_CHECK_EN defined, wb to x4 at cnt=0: sb_err=1 next cycle, held through flush, cleared by reset_n.
